// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Inter-stage pipeline register with a valid/ready handshake and a two-entry
// skid buffer. The payload is split into a datapath part (DATA) and a control
// part (CTRL). CTRL of an empty or killed slot is zero, so downstream stages
// see a bubble.
//
// The main slot is the head of the queue and drives out_* directly from
// registers. The skid slot catches the one beat that can arrive while the
// head is stalled. in_ready therefore depends only on the held state and on
// flush. It never depends on out_ready, so no ready path runs through this
// stage.
//
// Ports
//   clk         in   1       clock, rising edge
//   reset       in   1       synchronous, active-high
//   flush       in   1       synchronous kill of every held beat
//   in_valid    in   1       upstream beat valid
//   in_ready    out  1       beat can be accepted this cycle
//   in_data     in   DATA_W  upstream datapath payload
//   in_ctrl     in   CTRL_W  upstream control payload
//   out_valid   out  1       head beat presented downstream
//   out_ready   in   1       downstream accepts the head beat
//   out_data    out  DATA_W  head datapath payload (0 when empty)
//   out_ctrl    out  CTRL_W  head control payload (0 when empty)
//   occupancy   out  2       number of held beats: 0, 1 or 2
//
// Optional feature, enabled by defining PIPE_SKID_STATS_EN:
//   stall_cnt   out  CNT_W   saturating count of cycles with out_valid & ~out_ready
//   bubble_cnt  out  CNT_W   saturating count of cycles with out_valid = 0
//   Both counters are cleared by reset only. flush does not clear them.
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    // The state encoding equals the occupancy, so occupancy comes straight from the state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic in_fire_s;
    logic out_fire_s;

    assign in_ready   = (state_q != FULL) & ~flush;
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = main_data_q;
    assign out_ctrl   = main_ctrl_q;
    assign occupancy  = state_q;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Next-state and slot-update logic. A flush overrides every normal transition.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Kill everything. Any out_fire in this cycle is ignored.
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
            skid_data_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else begin
                        state_d     = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        // Head leaves and the new beat takes its place in the same cycle.
                        state_d     = ONE;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire_s) begin
                        // Head is stalled, so the new beat parks in the skid slot.
                        state_d     = FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire_s) begin
                        state_d     = EMPTY;
                        main_data_d = '0;
                        main_ctrl_d = '0;
                    end else begin
                        state_d     = ONE;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        // The skid beat is always younger, so it moves to the head.
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = '0;
                        skid_ctrl_d = '0;
                    end else begin
                        state_d     = FULL;
                    end
                end
                default: begin
                    // Recover from an unreachable encoding by emptying the stage.
                    state_d     = EMPTY;
                    main_data_d = '0;
                    main_ctrl_d = '0;
                    skid_data_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    // State and slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Saturating statistics counters. They stop at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!out_valid && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter registers. Only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Bench for pipe_skid_reg. A queue-based reference model predicts the held
// beats. One negedge process compares every DUT output against that model and
// then advances the model using the inputs that will be sampled at the next
// rising edge. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    pipe_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .occupancy  (occupancy)
`ifdef PIPE_SKID_STATS_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } beat_t;

    beat_t             mq[$];      // model: held beats, head first
    logic [DATA_W-1:0] dlog[$];    // beats the DUT actually delivered
    int                stall_m  = 0;
    int                bubble_m = 0;
    bit                chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model, log deliveries, then advance the model for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
                chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
                chk("in_ready", {63'd0, in_ready}, {63'd0, (mq.size() < 2) && !flush});
                chk("out_data", 64'(out_data), (mq.size() > 0) ? 64'(mq[0].d) : 64'd0);
                chk("out_ctrl", 64'(out_ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
`ifdef PIPE_SKID_STATS_EN
                chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
                chk("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`endif
                if (out_valid && out_ready && !flush && !reset) dlog.push_back(out_data);
            end
            if (reset) begin
                mq.delete();
                stall_m  = 0;
                bubble_m = 0;
                chk_en   = 1'b1;
            end else begin
                if (mq.size() == 0 && bubble_m < 15) bubble_m++;
                if (mq.size() > 0 && !out_ready && stall_m < 15) stall_m++;
                if (flush) begin
                    mq.delete();
                end else begin
                    bit acc;
                    acc = in_valid && (mq.size() < 2);
                    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                    if (acc) mq.push_back({in_data, in_ctrl});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        cyc();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        in_ctrl   = 8'hFF;
        out_ready = 1'b0;

        // Reset held two cycles with in_valid high.
        cyc();
        cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_occupancy", {62'd0, occupancy}, 64'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        cyc();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h11 + 32'(i), 8'(i + 1));
            chk("stream_data", 64'(out_data), 64'(32'h11 + 32'(i)));
            chk("stream_occ", {62'd0, occupancy}, 64'd1);
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drain_occ", {62'd0, occupancy}, 64'd0);

        // Back-pressure into the skid slot.
        dlog.delete();
        out_ready = 1'b0;
        send(32'hA1, 8'h01);
        chk("bp_occ1", {62'd0, occupancy}, 64'd1);
        send(32'hA2, 8'h02);
        chk("bp_occ2", {62'd0, occupancy}, 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        send(32'hA3, 8'h03);
        chk("bp_hold_occ", {62'd0, occupancy}, 64'd2);
        chk("bp_hold_data", 64'(out_data), 64'hA1);
        cyc();
        chk("bp_stable_data", 64'(out_data), 64'hA1);
        chk("bp_stable_ctrl", 64'(out_ctrl), 64'h01);
        out_ready = 1'b1;
        cyc();
        chk("bp_rel_data", 64'(out_data), 64'hA2);
        cyc();
        chk("bp_rel_data3", 64'(out_data), 64'hA3);
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("bp_log_size", 64'(dlog.size()), 64'd3);
        if (dlog.size() == 3) begin
            chk("bp_log0", 64'(dlog[0]), 64'hA1);
            chk("bp_log1", 64'(dlog[1]), 64'hA2);
            chk("bp_log2", 64'(dlog[2]), 64'hA3);
        end

        // Flush while FULL with a beat in flight.
        out_ready = 1'b0;
        send(32'hB1, 8'h11);
        send(32'hB2, 8'h12);
        chk("fl_full", {62'd0, occupancy}, 64'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hB3;
        in_ctrl  = 8'h13;
        #1;
        chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", {62'd0, occupancy}, 64'd0);
        chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        cyc();
        chk("fl_no_accept", {62'd0, occupancy}, 64'd0);

        // Simultaneous in_fire and out_fire while holding one beat.
        out_ready = 1'b1;
        send(32'hC1, 8'h21);
        send(32'hC2, 8'h22);
        chk("sim_occ", {62'd0, occupancy}, 64'd1);
        chk("sim_data", 64'(out_data), 64'hC2);
        in_valid = 1'b0;
        cyc();

`ifdef PIPE_SKID_STATS_EN
        // Counter saturation, flush immunity and reset clearing.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        out_ready = 1'b0;
        send(32'hD1, 8'h31);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("st_stall_sat", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("st_flush_keep", 64'(stall_cnt), 64'd15);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("st_rst_stall", 64'(stall_cnt), 64'd0);
        chk("st_rst_bubble", 64'(bubble_cnt), 64'd0);
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
